// File: rtl/hamming_cam_engine_if.sv
// Bundled write, search-request and response ports of the Hamming CAM engine.
// The bench drives the master side; the engine sits on the slave side.
interface hamming_cam_engine_if #(
   parameter int WIDTH = 16,
   parameter int BANKS = 4,
   parameter int DEPTH = 16
);
   localparam int N  = BANKS * DEPTH;
   localparam int AW = $clog2(N);
   localparam int DW = $clog2(WIDTH + 1);
   localparam int CW = $clog2(N + 1);

   logic             wr_en;
   logic             wr_ready;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             wr_keep;
   logic             clr_all;
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_key;
   logic [DW-1:0]    req_thresh;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_hit;
   logic [AW-1:0]    rsp_addr;
   logic [DW-1:0]    rsp_dist;
   logic [DW-1:0]    rsp_conf;
   logic [CW-1:0]    rsp_count;
   logic             busy;

   modport master (
      output wr_en, wr_addr, wr_data, wr_keep, clr_all,
      output req_valid, req_key, req_thresh, rsp_ready,
      input  wr_ready, req_ready, rsp_valid, rsp_hit, rsp_addr,
      input  rsp_dist, rsp_conf, rsp_count, busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_keep, clr_all,
      input  req_valid, req_key, req_thresh, rsp_ready,
      output wr_ready, req_ready, rsp_valid, rsp_hit, rsp_addr,
      output rsp_dist, rsp_conf, rsp_count, busy
   );
endinterface

// File: rtl/hamming_cam_engine.sv
// Hamming-distance CAM: stores BANKS*DEPTH patterns and scans one row of every bank
// per cycle, reporting the nearest valid entry, its distance/confidence and a hit count.
module hamming_cam_engine #(
   parameter int WIDTH = 16,
   parameter int BANKS = 4,
   parameter int DEPTH = 16
) (
   input logic                clk,
   input logic                rst_n,
   hamming_cam_engine_if.slave bus
);
   localparam int N  = BANKS * DEPTH;
   localparam int AW = $clog2(N);
   localparam int DW = $clog2(WIDTH + 1);
   localparam int CW = $clog2(N + 1);
   localparam int BW = $clog2(BANKS);
   localparam int RW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] mem [BANKS][DEPTH];
   logic [N-1:0]     valid;

   logic [WIDTH-1:0] key;
   logic [DW-1:0]    thresh;
   logic [RW-1:0]    row;
   logic             found;
   logic [AW-1:0]    best_addr;
   logic [DW-1:0]    best_dist;
   logic [CW-1:0]    count;

   logic             found_n;
   logic [AW-1:0]    best_addr_n;
   logic [DW-1:0]    best_dist_n;
   logic [CW-1:0]    count_n;

   logic [DW-1:0]    row_dist [BANKS];
   logic [AW-1:0]    row_addr [BANKS];

   logic             rsp_hit_q;
   logic [AW-1:0]    rsp_addr_q;
   logic [DW-1:0]    rsp_dist_q;
   logic [DW-1:0]    rsp_conf_q;
   logic [CW-1:0]    rsp_count_q;

   logic             in_idle;
   logic             accept;
   logic             last_row;
   logic [BW-1:0]    wr_bank;
   logic [RW-1:0]    wr_row;

   function automatic logic [DW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [DW-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) c = c + DW'(v[i]);
      return c;
   endfunction

   assign in_idle  = (state == IDLE);
   assign accept   = in_idle && bus.req_valid;
   assign last_row = (row == RW'(DEPTH - 1));
   assign wr_bank  = bus.wr_addr[BW-1:0];
   assign wr_row   = bus.wr_addr[AW-1:BW];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.req_valid) state_next = SCAN;
         SCAN:    if (last_row)      state_next = DONE;
         DONE:    if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.wr_ready  = in_idle;
      bus.req_ready = in_idle;
      bus.rsp_valid = (state == DONE);
      bus.busy      = !in_idle;
   end

   // clr_all beats a same-cycle write, so the pattern store is left untouched then too.
   always_ff @(posedge clk) begin
      if (rst_n && in_idle && bus.wr_en && bus.wr_keep && !bus.clr_all)
         mem[wr_bank][wr_row] <= bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                     valid <= '0;
      else if (in_idle && bus.clr_all) valid <= '0;
      else if (in_idle && bus.wr_en)   valid[bus.wr_addr] <= bus.wr_keep;
   end

   always_comb begin
      for (int b = 0; b < BANKS; b++) begin
         row_dist[b] = popcount(key ^ mem[b][row]);
         row_addr[b] = {row, BW'(b)};
      end
   end

   // Banks are visited in ascending address order with a strict compare, so ties keep the lowest address.
   always_comb begin
      found_n     = found;
      best_addr_n = best_addr;
      best_dist_n = best_dist;
      count_n     = count;
      for (int b = 0; b < BANKS; b++) begin
         if (valid[row_addr[b]]) begin
            if (!found_n || row_dist[b] < best_dist_n) begin
               found_n     = 1'b1;
               best_addr_n = row_addr[b];
               best_dist_n = row_dist[b];
            end
            if (row_dist[b] <= thresh) count_n = count_n + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key         <= '0;
         thresh      <= '0;
         row         <= '0;
         found       <= 1'b0;
         best_addr   <= '0;
         best_dist   <= '1;
         count       <= '0;
         rsp_hit_q   <= 1'b0;
         rsp_addr_q  <= '0;
         rsp_dist_q  <= '0;
         rsp_conf_q  <= '0;
         rsp_count_q <= '0;
      end else if (accept) begin
         key       <= bus.req_key;
         thresh    <= bus.req_thresh;
         row       <= '0;
         found     <= 1'b0;
         best_addr <= '0;
         best_dist <= '1;
         count     <= '0;
      end else if (state == SCAN) begin
         row       <= row + RW'(1);
         found     <= found_n;
         best_addr <= best_addr_n;
         best_dist <= best_dist_n;
         count     <= count_n;
         if (last_row) begin
            rsp_hit_q   <= found_n && (best_dist_n <= thresh);
            rsp_addr_q  <= found_n ? best_addr_n : '0;
            rsp_dist_q  <= found_n ? best_dist_n : '1;
            rsp_conf_q  <= found_n ? (DW'(WIDTH) - best_dist_n) : '0;
            rsp_count_q <= count_n;
         end
      end
   end

   assign bus.rsp_hit   = rsp_hit_q;
   assign bus.rsp_addr  = rsp_addr_q;
   assign bus.rsp_dist  = rsp_dist_q;
   assign bus.rsp_conf  = rsp_conf_q;
   assign bus.rsp_count = rsp_count_q;
endmodule

// File: tb/tb_hamming_cam_engine.sv
// Directed bench for hamming_cam_engine: each scenario task drives the engine and
// checks the response against hand-computed distances and counts.
module tb_hamming_cam_engine;
   localparam int WIDTH = 16;
   localparam int BANKS = 4;
   localparam int DEPTH = 16;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   hamming_cam_engine_if #(.WIDTH(WIDTH), .BANKS(BANKS), .DEPTH(DEPTH)) bus ();

   hamming_cam_engine #(.WIDTH(WIDTH), .BANKS(BANKS), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic write_entry(input int addr, input logic [15:0] data, input logic keep);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 6'(addr);
      bus.wr_data = data;
      bus.wr_keep = keep;
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic clear_all();
      @(negedge clk);
      bus.clr_all = 1'b1;
      @(negedge clk);
      bus.clr_all = 1'b0;
   endtask

   // Any wr_en/clr_all already raised by the caller rides along with the accepting edge.
   task automatic search(input logic [15:0] key, input logic [4:0] th, output int lat);
      @(negedge clk);
      bus.req_key    = key;
      bus.req_thresh = th;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.wr_en     = 1'b0;
      bus.clr_all   = 1'b0;
      lat = 0;
      while (!bus.rsp_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_rsp();
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%0b want=0", bus.rsp_valid); end
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_req_ready got=%0b want=1", bus.req_ready); end
      total++; if (bus.wr_ready !== 1'b1)  begin bad++; $display("[TB] FAIL reset_wr_ready got=%0b want=1", bus.wr_ready); end
      total++; if (bus.busy !== 1'b0)      begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", bus.busy); end
      total++; if (bus.rsp_dist !== 5'd0)  begin bad++; $display("[TB] FAIL reset_rsp_dist got=%0d want=0", bus.rsp_dist); end
   endtask

   task automatic test_empty();
      int lat;
      search(16'h0000, 5'd16, lat);
      total++; if (lat !== 16)              begin bad++; $display("[TB] FAIL empty_latency got=%0d want=16", lat); end
      total++; if (bus.busy !== 1'b1)       begin bad++; $display("[TB] FAIL empty_busy got=%0b want=1", bus.busy); end
      total++; if (bus.rsp_hit !== 1'b0)    begin bad++; $display("[TB] FAIL empty_hit got=%0b want=0", bus.rsp_hit); end
      total++; if (bus.rsp_addr !== 6'd0)   begin bad++; $display("[TB] FAIL empty_addr got=%0d want=0", bus.rsp_addr); end
      total++; if (bus.rsp_dist !== 5'd31)  begin bad++; $display("[TB] FAIL empty_dist got=%0d want=31", bus.rsp_dist); end
      total++; if (bus.rsp_conf !== 5'd0)   begin bad++; $display("[TB] FAIL empty_conf got=%0d want=0", bus.rsp_conf); end
      total++; if (bus.rsp_count !== 7'd0)  begin bad++; $display("[TB] FAIL empty_count got=%0d want=0", bus.rsp_count); end
      release_rsp();
   endtask

   task automatic test_exact_match();
      int lat;
      write_entry(5, 16'hA5A5, 1'b1);
      write_entry(9, 16'hA5A4, 1'b1);
      search(16'hA5A5, 5'd0, lat);
      total++; if (lat !== 16)              begin bad++; $display("[TB] FAIL exact_latency got=%0d want=16", lat); end
      total++; if (bus.rsp_hit !== 1'b1)    begin bad++; $display("[TB] FAIL exact_hit got=%0b want=1", bus.rsp_hit); end
      total++; if (bus.rsp_addr !== 6'd5)   begin bad++; $display("[TB] FAIL exact_addr got=%0d want=5", bus.rsp_addr); end
      total++; if (bus.rsp_dist !== 5'd0)   begin bad++; $display("[TB] FAIL exact_dist got=%0d want=0", bus.rsp_dist); end
      total++; if (bus.rsp_conf !== 5'd16)  begin bad++; $display("[TB] FAIL exact_conf got=%0d want=16", bus.rsp_conf); end
      total++; if (bus.rsp_count !== 7'd1)  begin bad++; $display("[TB] FAIL exact_count_t0 got=%0d want=1", bus.rsp_count); end
      release_rsp();
      search(16'hA5A5, 5'd1, lat);
      total++; if (bus.rsp_count !== 7'd2)  begin bad++; $display("[TB] FAIL exact_count_t1 got=%0d want=2", bus.rsp_count); end
      total++; if (bus.rsp_addr !== 6'd5)   begin bad++; $display("[TB] FAIL exact_addr_t1 got=%0d want=5", bus.rsp_addr); end
      release_rsp();
   endtask

   task automatic test_tie();
      int lat;
      clear_all();
      write_entry(12, 16'h00FF, 1'b1);
      write_entry(3, 16'h00FF, 1'b1);
      search(16'h00FE, 5'd2, lat);
      total++; if (bus.rsp_addr !== 6'd3)   begin bad++; $display("[TB] FAIL tie_addr got=%0d want=3", bus.rsp_addr); end
      total++; if (bus.rsp_dist !== 5'd1)   begin bad++; $display("[TB] FAIL tie_dist got=%0d want=1", bus.rsp_dist); end
      total++; if (bus.rsp_conf !== 5'd15)  begin bad++; $display("[TB] FAIL tie_conf got=%0d want=15", bus.rsp_conf); end
      total++; if (bus.rsp_count !== 7'd2)  begin bad++; $display("[TB] FAIL tie_count got=%0d want=2", bus.rsp_count); end
      release_rsp();
      write_entry(3, 16'h0000, 1'b0);
      search(16'h00FE, 5'd2, lat);
      total++; if (bus.rsp_addr !== 6'd12)  begin bad++; $display("[TB] FAIL inval_addr got=%0d want=12", bus.rsp_addr); end
      total++; if (bus.rsp_count !== 7'd1)  begin bad++; $display("[TB] FAIL inval_count got=%0d want=1", bus.rsp_count); end
      total++; if (bus.rsp_hit !== 1'b1)    begin bad++; $display("[TB] FAIL inval_hit got=%0b want=1", bus.rsp_hit); end
      release_rsp();
   endtask

   task automatic test_no_hit();
      int lat;
      clear_all();
      write_entry(63, 16'hFFFF, 1'b1);
      search(16'h0000, 5'd15, lat);
      total++; if (bus.rsp_hit !== 1'b0)    begin bad++; $display("[TB] FAIL far_hit got=%0b want=0", bus.rsp_hit); end
      total++; if (bus.rsp_addr !== 6'd63)  begin bad++; $display("[TB] FAIL far_addr got=%0d want=63", bus.rsp_addr); end
      total++; if (bus.rsp_dist !== 5'd16)  begin bad++; $display("[TB] FAIL far_dist got=%0d want=16", bus.rsp_dist); end
      total++; if (bus.rsp_conf !== 5'd0)   begin bad++; $display("[TB] FAIL far_conf got=%0d want=0", bus.rsp_conf); end
      total++; if (bus.rsp_count !== 7'd0)  begin bad++; $display("[TB] FAIL far_count got=%0d want=0", bus.rsp_count); end
      release_rsp();
   endtask

   task automatic test_backpressure();
      int lat;
      clear_all();
      write_entry(20, 16'h0F0F, 1'b1);
      search(16'h0F0F, 5'd0, lat);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 6'd7;
      bus.wr_data = 16'h0F0F;
      bus.wr_keep = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         total++; if (bus.rsp_valid !== 1'b1)  begin bad++; $display("[TB] FAIL hold_valid[%0d] got=%0b want=1", i, bus.rsp_valid); end
         total++; if (bus.rsp_addr !== 6'd20)  begin bad++; $display("[TB] FAIL hold_addr[%0d] got=%0d want=20", i, bus.rsp_addr); end
         total++; if (bus.rsp_count !== 7'd1)  begin bad++; $display("[TB] FAIL hold_count[%0d] got=%0d want=1", i, bus.rsp_count); end
         total++; if (bus.req_ready !== 1'b0)  begin bad++; $display("[TB] FAIL hold_req_ready[%0d] got=%0b want=0", i, bus.req_ready); end
         total++; if (bus.wr_ready !== 1'b0)   begin bad++; $display("[TB] FAIL hold_wr_ready[%0d] got=%0b want=0", i, bus.wr_ready); end
      end
      bus.wr_en = 1'b0;
      release_rsp();
      total++; if (bus.rsp_valid !== 1'b0)  begin bad++; $display("[TB] FAIL release_valid got=%0b want=0", bus.rsp_valid); end
      total++; if (bus.req_ready !== 1'b1)  begin bad++; $display("[TB] FAIL release_req_ready got=%0b want=1", bus.req_ready); end
      search(16'h0F0F, 5'd0, lat);
      total++; if (bus.rsp_count !== 7'd1)  begin bad++; $display("[TB] FAIL dropped_wr_count got=%0d want=1", bus.rsp_count); end
      total++; if (bus.rsp_addr !== 6'd20)  begin bad++; $display("[TB] FAIL dropped_wr_addr got=%0d want=20", bus.rsp_addr); end
      release_rsp();
   endtask

   task automatic test_collisions();
      int lat;
      clear_all();
      write_entry(1, 16'h5555, 1'b1);
      @(negedge clk);
      bus.clr_all = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_addr = 6'd2;
      bus.wr_data = 16'h5555;
      bus.wr_keep = 1'b1;
      @(negedge clk);
      bus.clr_all = 1'b0;
      bus.wr_en   = 1'b0;
      search(16'h5555, 5'd0, lat);
      total++; if (bus.rsp_count !== 7'd0)  begin bad++; $display("[TB] FAIL clr_wr_count got=%0d want=0", bus.rsp_count); end
      total++; if (bus.rsp_hit !== 1'b0)    begin bad++; $display("[TB] FAIL clr_wr_hit got=%0b want=0", bus.rsp_hit); end
      release_rsp();
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 6'd40;
      bus.wr_data = 16'h3333;
      bus.wr_keep = 1'b1;
      search(16'h3333, 5'd0, lat);
      total++; if (bus.rsp_hit !== 1'b1)    begin bad++; $display("[TB] FAIL wr_req_hit got=%0b want=1", bus.rsp_hit); end
      total++; if (bus.rsp_addr !== 6'd40)  begin bad++; $display("[TB] FAIL wr_req_addr got=%0d want=40", bus.rsp_addr); end
      total++; if (bus.rsp_count !== 7'd1)  begin bad++; $display("[TB] FAIL wr_req_count got=%0d want=1", bus.rsp_count); end
      release_rsp();
      @(negedge clk);
      bus.clr_all = 1'b1;
      search(16'h3333, 5'd0, lat);
      total++; if (bus.rsp_count !== 7'd0)  begin bad++; $display("[TB] FAIL clr_req_count got=%0d want=0", bus.rsp_count); end
      total++; if (bus.rsp_dist !== 5'd31)  begin bad++; $display("[TB] FAIL clr_req_dist got=%0d want=31", bus.rsp_dist); end
      release_rsp();
   endtask

   task automatic test_reset_mid_scan();
      int lat;
      int seen;
      write_entry(2, 16'h1111, 1'b1);
      @(negedge clk);
      bus.req_key    = 16'h1111;
      bus.req_thresh = 5'd0;
      bus.req_valid  = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      total++; if (bus.busy !== 1'b0)       begin bad++; $display("[TB] FAIL midrst_busy got=%0b want=0", bus.busy); end
      total++; if (bus.req_ready !== 1'b1)  begin bad++; $display("[TB] FAIL midrst_req_ready got=%0b want=1", bus.req_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) seen++;
      end
      total++; if (seen !== 0)              begin bad++; $display("[TB] FAIL midrst_no_rsp got=%0d want=0", seen); end
      search(16'h1111, 5'd0, lat);
      total++; if (bus.rsp_hit !== 1'b0)    begin bad++; $display("[TB] FAIL midrst_hit got=%0b want=0", bus.rsp_hit); end
      total++; if (bus.rsp_count !== 7'd0)  begin bad++; $display("[TB] FAIL midrst_count got=%0d want=0", bus.rsp_count); end
      release_rsp();
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      rst_n          = 1'b0;
      bus.wr_en      = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.wr_keep    = 1'b0;
      bus.clr_all    = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_key    = '0;
      bus.req_thresh = '0;
      bus.rsp_ready  = 1'b0;
      test_reset();
      test_empty();
      test_exact_match();
      test_tie();
      test_no_hit();
      test_backpressure();
      test_collisions();
      test_reset_mid_scan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
